// File: rtl/multi_tick_timer.sv
// Multi-channel programmable tick generator: a shared base prescaler produces a
// strobe that NCH channels divide by run-time scale values (free-run or one-shot).
module multi_tick_timer #(
  parameter int CLK_DIV = 50000,
  parameter int NCH     = 4,
  parameter int SCALE_W = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic [NCH*SCALE_W-1:0]   scale,
  input  logic [NCH-1:0]           oneshot,
  input  logic [NCH-1:0]           start,
  output logic                     base_tick,
  output logic [NCH-1:0]           tick,
  output logic [NCH-1:0]           sq,
  output logic [NCH-1:0]           done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] r_pre;
  logic          r_base_tick;
  logic          w_clear;
  logic          w_strobe;

  assign w_clear  = rst | clr;
  assign w_strobe = en && (r_pre == PRE_LAST);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_pre       <= '0;
      r_base_tick <= 1'b0;
    end else begin
      r_base_tick <= w_strobe;
      if (w_strobe)
        r_pre <= '0;
      else if (en)
        r_pre <= r_pre + PW'(1);
    end
  end

  assign base_tick = r_base_tick;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [SCALE_W-1:0] w_scale;
    logic [SCALE_W-1:0] r_cnt;
    logic               r_tick;
    logic               r_sq;
    logic               r_done;
    logic               w_halted;
    logic               w_terminal;

    assign w_scale  = scale[g*SCALE_W +: SCALE_W];
    assign w_halted = oneshot[g] & r_done;
    // Compare with >= so a scale lowered below the current count ends the
    // period at the next strobe instead of wrapping the counter.
    assign w_terminal = (r_cnt >= (w_scale - SCALE_W'(1)));

    always_ff @(posedge clk) begin
      if (w_clear || (w_scale == '0)) begin
        r_cnt  <= '0;
        r_tick <= 1'b0;
        r_sq   <= 1'b0;
        r_done <= 1'b0;
      end else if (start[g]) begin
        r_cnt  <= '0;
        r_tick <= 1'b0;
        r_done <= 1'b0;
      end else begin
        r_tick <= 1'b0;
        if (!oneshot[g])
          r_done <= 1'b0;
        if (w_strobe && !w_halted) begin
          if (w_terminal) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
            r_sq   <= ~r_sq;
            if (oneshot[g])
              r_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + SCALE_W'(1);
          end
        end
      end
    end

    assign tick[g] = r_tick;
    assign sq[g]   = r_sq;
    assign done[g] = r_done;
  end

endmodule

// File: tb/tb_multi_tick_timer.sv
// Randomized and directed bench for multi_tick_timer against a strobe-counting
// reference model (CLK_DIV=4, NCH=2, SCALE_W=4).
module tb_multi_tick_timer;

  localparam int CLK_DIV = 4;
  localparam int NCH     = 2;
  localparam int SCALE_W = 4;

  logic                   clk = 1'b0;
  logic                   rst, en, clr;
  logic [NCH*SCALE_W-1:0] scale;
  logic [NCH-1:0]         oneshot, start;
  logic                   base_tick;
  logic [NCH-1:0]         tick, sq, done;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: enabled cycles into the current base period, and strobes
  // seen by each channel since its last terminal event or restart.
  int m_phase;
  int m_seen [NCH];
  bit m_base;
  bit m_tick [NCH];
  bit m_sq   [NCH];
  bit m_done [NCH];

  multi_tick_timer #(.CLK_DIV(CLK_DIV), .NCH(NCH), .SCALE_W(SCALE_W)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .scale(scale),
    .oneshot(oneshot), .start(start), .base_tick(base_tick),
    .tick(tick), .sq(sq), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int scale_of(input int ch);
    return int'(scale[ch*SCALE_W +: SCALE_W]);
  endfunction

  task automatic model_step();
    bit strobe;
    int s;
    if (rst || clr) begin
      m_phase = 0;
      m_base  = 0;
      for (int c = 0; c < NCH; c++) begin
        m_seen[c] = 0; m_tick[c] = 0; m_sq[c] = 0; m_done[c] = 0;
      end
      return;
    end
    strobe = en && (m_phase == CLK_DIV - 1);
    if (en) m_phase = (m_phase + 1) % CLK_DIV;
    m_base = strobe;
    for (int c = 0; c < NCH; c++) begin
      s = scale_of(c);
      m_tick[c] = 0;
      if (s == 0) begin
        m_seen[c] = 0; m_sq[c] = 0; m_done[c] = 0;
      end else if (start[c]) begin
        m_seen[c] = 0; m_done[c] = 0;
      end else begin
        if (!oneshot[c]) m_done[c] = 0;
        if (strobe && !(oneshot[c] && m_done[c])) begin
          // A period of S strobes ends on the S-th one (or sooner if S shrank).
          if (m_seen[c] + 1 >= s) begin
            m_seen[c] = 0;
            m_tick[c] = 1;
            m_sq[c]   = !m_sq[c];
            if (oneshot[c]) m_done[c] = 1;
          end else begin
            m_seen[c]++;
          end
        end
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("base_tick", base_tick, m_base);
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("tick%0d", c), tick[c], m_tick[c]);
      check($sformatf("sq%0d", c),   sq[c],   m_sq[c]);
      check($sformatf("done%0d", c), done[c], m_done[c]);
    end
  endtask

  task automatic wait_tick0(output int n, input int limit);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!tick[0] && n < limit);
    check("tick0_seen", tick[0], 1'b1);
    check("tick0_with_base", base_tick, 1'b1);
  endtask

  task automatic set_scale(input int ch, input int v);
    scale[ch*SCALE_W +: SCALE_W] = SCALE_W'(v);
  endtask

  task automatic pulse_clr();
    clr = 1'b1; cyc(); clr = 1'b0;
  endtask

  function automatic bit terminal_next0();
    return en && !rst && !clr && (m_phase == CLK_DIV - 1) && (scale_of(0) > 0)
           && !start[0] && !(oneshot[0] && m_done[0]) && (m_seen[0] + 1 >= scale_of(0));
  endfunction

  initial begin
    int n, cnt;
    m_phase = 0; m_base = 0;
    for (int c = 0; c < NCH; c++) begin
      m_seen[c] = 0; m_tick[c] = 0; m_sq[c] = 0; m_done[c] = 0;
    end
    rst = 1'b1; en = 1'b1; clr = 1'b0; scale = '0; oneshot = '0; start = '0;
    set_scale(0, 3);
    cyc();
    check("rst_outputs", {base_tick, tick, sq, done}, 32'd0);
    rst = 1'b0;

    // 1: base period 4, ch0 period 12, ch1 off
    wait_tick0(n, 20);
    check("s1_first", n, 12);
    wait_tick0(n, 20);
    check("s1_period", n, 12);
    wait_tick0(n, 20);
    check("s1_period2", n, 12);
    check("s1_ch1_idle", {tick[1], sq[1]}, 32'd0);

    // 2: scale 1 tracks the base strobe
    set_scale(0, 1);
    repeat (24) begin
      cyc();
      check("s2_eq_base", tick[0], base_tick);
    end

    // 3: shrink scale mid-count
    pulse_clr();
    set_scale(0, 10);
    cnt = 0;
    while (m_seen[0] != 7 && cnt < 100) begin cyc(); cnt++; end
    check("s3_reach7", m_seen[0], 7);
    set_scale(0, 3);
    wait_tick0(n, 8);
    check("s3_next_strobe", n <= 4, 1);
    wait_tick0(n, 20);
    check("s3_period", n, 12);

    // 4: one-shot, halt, re-arm
    pulse_clr();
    oneshot[0] = 1'b1;
    set_scale(0, 2);
    wait_tick0(n, 30);
    check("s4_first", n, 8);
    check("s4_done", done[0], 1'b1);
    cnt = 0;
    repeat (20 * CLK_DIV) begin cyc(); if (tick[0]) cnt++; end
    check("s4_halted", cnt, 0);
    start[0] = 1'b1; cyc(); start[0] = 1'b0;
    check("s4_rearm_done", done[0], 1'b0);
    wait_tick0(n, 20);
    check("s4_rearm_lat", (n >= 5 && n <= 8), 1);
    oneshot[0] = 1'b0;
    cyc();
    check("s4_freerun_done", done[0], 1'b0);

    // 5: enable gap stretches the period by its length
    pulse_clr();
    set_scale(0, 3);
    wait_tick0(n, 20);
    repeat (5) cyc();
    en = 1'b0;
    cnt = 0;
    repeat (7) begin cyc(); if (base_tick || tick[0]) cnt++; end
    check("s5_gap_quiet", cnt, 0);
    en = 1'b1;
    wait_tick0(n, 40);
    check("s5_period", n + 12, 19);

    // 6: clr / rst on a terminal strobe
    for (int k = 0; k < 2; k++) begin
      cnt = 0;
      while (!terminal_next0() && cnt < 40) begin cyc(); cnt++; end
      check("s6_found_term", terminal_next0(), 1);
      if (k == 0) clr = 1'b1; else rst = 1'b1;
      cyc();
      clr = 1'b0; rst = 1'b0;
      check("s6_cleared", {tick[0], sq[0], base_tick}, 32'd0);
      wait_tick0(n, 20);
      check("s6_restart", n, 12);
    end

    // Random phase
    repeat (800) begin
      rst = ($urandom_range(199) == 0);
      clr = ($urandom_range(99) == 0);
      en  = ($urandom_range(9) != 0);
      for (int c = 0; c < NCH; c++) begin
        start[c] = ($urandom_range(39) == 0);
        if ($urandom_range(49) == 0) set_scale(c, $urandom_range(5));
        if ($urandom_range(59) == 0) oneshot[c] = ~oneshot[c];
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
